wb_ext_regbank: RTL and testbench
=================================

# wb_ext_regbank

Parametrised Wishbone register bank that terminates the SoC's 32-bit external I/O port (`wb_ext_io_*`), replacing the constant tie-offs on that port with live control/status registers for the debugger. It exposes a configurable number of R/W control words as flat outputs and read-only status words as flat inputs. Response latency and classic/pipelined mode are selectable. An optional edge-triggered interrupt block is available.

## Interface
Parameters:
- `NUM_CTRL`, 8: number of R/W control words (1..32).
- `NUM_STAT`, 4: number of read-only status words (0..16).
- `ACK_LAT`, 1: cycles from accept to ack (1..4).
- `PIPELINED`, 1: 1 = back-to-back acceptance; 0 = classic, one outstanding request.
- `BASE_ADDR`, 30'h0: word-address base; the low 6 bits must be zero.
- `CTRL_RESET`, 32'h0: reset value of every control word.

Ports:
- `system_clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wb_cyc` in 1, `wb_stb` in 1, `wb_we` in 1: Wishbone master controls.
- `wb_adr` in 30: word address.
- `wb_dat_w` in 32: write data.
- `wb_sel` in 4: byte enables.
- `wb_dat_r` out 32: read data.
- `wb_ack` out 1: response strobe.
- `wb_stall` out 1: request not accepted.
- `ctrl_out` out NUM_CTRL*32: control words; word i is at bits [32i+31:32i].
- `stat_in` in max(NUM_STAT,1)*32: status words.
- `irq` out 1: interrupt request; present only with `WB_EXT_REGBANK_IRQ_EN`.

## Operation
- Hit: `wb_adr[29:6] == BASE_ADDR[29:6]`. Local index `idx = wb_adr[5:0]`.
- Map:
  - idx 0..NUM_CTRL-1 is control.
  - Next NUM_STAT indices are status.
  - With IRQ: next index is IRQ_PEND (W1C), the one after is IRQ_MASK.
  - Everything else is unmapped.
- Accept: `wb_cyc & wb_stb & ~wb_stall`. Non-hit addresses are still accepted and acked, as unmapped accesses.
- Write to control: byte k is updated only if `wb_sel[k]`. Writes to status or unmapped locations are discarded and still acked.
- Read data is captured at accept:
  - control: current register value;
  - status: the `stat_in` word;
  - unmapped: 32'hDEADBEEF.
- Write response returns `wb_dat_r` = 0.
- Bus abort: `wb_cyc` low flushes every in-flight response, so no ack is emitted for it. Writes already committed persist.
- IRQ (when compiled in):
  - Track the previous value of `stat_in` word 0, bits 31:0.
  - `pend |= stat_in[31:0] & ~prev` each cycle.
  - A write to IRQ_PEND clears the bits set in its data. If a new edge and a clear hit the same bit in the same cycle, set wins.
  - `irq = |(pend & mask)`, registered.

## Timing
- Reset values: `wb_ack`=0, `wb_stall`=0, `wb_dat_r`=0, `ctrl_out`={NUM_CTRL{CTRL_RESET}}, `pend`=0, `mask`=0, `irq`=0.
- Accept at cycle T:
  - a write is visible on `ctrl_out` from T+1;
  - `wb_ack` and `wb_dat_r` are valid for exactly one cycle at T+ACK_LAT.
- A read accepted at T+1 after a write at T returns the new value.
- PIPELINED=1:
  - `wb_stall` is always 0;
  - one request is accepted per cycle;
  - acks return in order.
- PIPELINED=0:
  - `wb_stall`=1 from T+1 through T+ACK_LAT inclusive;
  - the next accept is at T+ACK_LAT+1 at the earliest.
- A flush clears the busy state in the same cycle `wb_cyc` is seen low.
- Asynchronous reset mid-transaction drops all pending acks. Outputs go to their reset values immediately.

## Configuration
- `WB_EXT_REGBANK_IRQ_EN` defined:
  - IRQ_PEND and IRQ_MASK registers exist;
  - `irq` port present;
  - edge detector active.
- Undefined:
  - no `irq` port;
  - those two indices read as unmapped (DEADBEEF);
  - no edge-detect flops.

## Structure
- Package `wb_ext_regbank_pkg` holds:
  - `WB_ADR_W`=30, `WB_DAT_W`=32, `WB_SEL_W`=4;
  - `UNMAPPED_DATA`=32'hDEADBEEF;
  - `LOCAL_IDX_W`=6;
  - a typedef for the response entry {valid, data}.
- Sub-module `wb_ack_pipe`: ACK_LAT-deep shift register of response entries, with synchronous flush. It is instantiated once.

## Test plan
- Reset with CTRL_RESET=32'hA5A5A5A5 -> all `ctrl_out` words = A5A5A5A5; ack, stall, dat_r = 0.
- Write 32'h12345678 to idx 2 with sel=4'b0101, then read idx 2 -> reads A534A578; ack at T+ACK_LAT for each, for ACK_LAT=1 and ACK_LAT=3.
- PIPELINED=1, ACK_LAT=2, 4 back-to-back reads of idx 0..3 -> stall stays 0; 4 consecutive acks starting at T+2, in order.
- PIPELINED=0, ACK_LAT=3 -> stall high for 3 cycles after accept; second request accepted at T+4.
- Read unmapped idx 63 -> DEADBEEF. Drop cyc one cycle after a read accept with ACK_LAT=3 -> no ack.
- IRQ_EN, mask=1: `stat_in[0]` rises -> irq=1. W1C of bit 0 in the same cycle as a new edge -> pend stays 1; a later W1C -> irq=0.

Source files
------------

// File: rtl/wb_ext_regbank_pkg.sv
// Shared widths, constants and types for the external Wishbone register bank.
package wb_ext_regbank_pkg;

    localparam int unsigned WB_ADR_W    = 30;
    localparam int unsigned WB_DAT_W    = 32;
    localparam int unsigned WB_SEL_W    = 4;
    localparam int unsigned LOCAL_IDX_W = 6;

    localparam logic [WB_DAT_W-1:0] UNMAPPED_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic                valid;
        logic [WB_DAT_W-1:0] data;
    } wb_rsp_t;

    typedef enum logic [2:0] {
        RGN_CTRL,
        RGN_STAT,
        RGN_PEND,
        RGN_MASK,
        RGN_NONE
    } wb_region_t;

endpackage

// File: rtl/wb_ext_regbank_ack_pipe.sv
// Fixed-latency response delay line; a synchronous flush drops every in-flight entry.
module wb_ack_pipe
    import wb_ext_regbank_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [WB_DAT_W-1:0] in_data,
    output logic                out_valid,
    output logic [WB_DAT_W-1:0] out_data
);

    wb_rsp_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{valid: in_valid, data: in_data};
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_valid = stage[DEPTH-1].valid;
    assign out_data  = stage[DEPTH-1].data;

endmodule

// File: rtl/wb_ext_regbank.sv
// Wishbone control/status register bank on the external I/O port.
// Optional edge-triggered interrupt block: define WB_EXT_REGBANK_IRQ_EN.
module wb_ext_regbank
    import wb_ext_regbank_pkg::*;
#(
    parameter int unsigned NUM_CTRL   = 8,
    parameter int unsigned NUM_STAT   = 4,
    parameter int unsigned ACK_LAT    = 1,
    parameter int unsigned PIPELINED  = 1,
    parameter logic [29:0] BASE_ADDR  = 30'h0,
    parameter logic [31:0] CTRL_RESET = 32'h0
) (
    input  logic                                    system_clk,
    input  logic                                    rst,
    input  logic                                    wb_cyc,
    input  logic                                    wb_stb,
    input  logic                                    wb_we,
    input  logic [29:0]                             wb_adr,
    input  logic [31:0]                             wb_dat_w,
    input  logic [3:0]                              wb_sel,
    output logic [31:0]                             wb_dat_r,
    output logic                                    wb_ack,
    output logic                                    wb_stall,
    output logic [NUM_CTRL*32-1:0]                  ctrl_out,
    input  logic [(NUM_STAT > 0 ? NUM_STAT : 1)*32-1:0] stat_in
`ifdef WB_EXT_REGBANK_IRQ_EN
    ,
    output logic                                    irq
`endif
);

    localparam int unsigned PEND_IDX = NUM_CTRL + NUM_STAT;
    localparam int unsigned MASK_IDX = PEND_IDX + 1;

    logic [31:0]  ctrl_q [NUM_CTRL];
    logic         hit;
    int unsigned  idx_n;
    wb_region_t   region;
    logic [31:0]  rd_data;
    logic         accept;
    logic         flush;
    logic [2:0]   busy_cnt;

`ifdef WB_EXT_REGBANK_IRQ_EN
    logic [31:0]  stat_prev;
    logic [31:0]  irq_pend;
    logic [31:0]  irq_mask;
    logic [31:0]  pend_clr;
    logic         irq_q;
`endif

    assign hit    = (wb_adr[29:6] == BASE_ADDR[29:6]);
    assign idx_n  = {26'b0, wb_adr[5:0]};
    assign flush  = ~wb_cyc;
    assign accept = wb_cyc & wb_stb & ~wb_stall;

    always_comb begin
        region = RGN_NONE;
        if (hit) begin
            if (idx_n < NUM_CTRL)                 region = RGN_CTRL;
            else if (idx_n < NUM_CTRL + NUM_STAT) region = RGN_STAT;
`ifdef WB_EXT_REGBANK_IRQ_EN
            else if (idx_n == PEND_IDX)           region = RGN_PEND;
            else if (idx_n == MASK_IDX)           region = RGN_MASK;
`endif
        end
    end

    always_comb begin
        rd_data = UNMAPPED_DATA;
        case (region)
            RGN_CTRL:
                for (int unsigned i = 0; i < NUM_CTRL; i++)
                    if (idx_n == i) rd_data = ctrl_q[i];
            RGN_STAT:
                for (int unsigned i = 0; i < NUM_STAT; i++)
                    if (idx_n == NUM_CTRL + i) rd_data = stat_in[i*32 +: 32];
`ifdef WB_EXT_REGBANK_IRQ_EN
            RGN_PEND: rd_data = irq_pend;
            RGN_MASK: rd_data = irq_mask;
`endif
            default:  rd_data = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= CTRL_RESET;
        end else if (accept && wb_we && region == RGN_CTRL) begin
            for (int unsigned i = 0; i < NUM_CTRL; i++)
                if (idx_n == i)
                    for (int unsigned k = 0; k < WB_SEL_W; k++)
                        if (wb_sel[k]) ctrl_q[i][8*k +: 8] <= wb_dat_w[8*k +: 8];
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int unsigned i = 0; i < NUM_CTRL; i++) ctrl_out[i*32 +: 32] = ctrl_q[i];
    end

    // Classic mode: busy counts down the response latency; dropping cyc cancels it at once.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst)                             busy_cnt <= '0;
        else if (!wb_cyc)                    busy_cnt <= '0;
        else if (accept && PIPELINED == 0)   busy_cnt <= 3'(ACK_LAT);
        else if (busy_cnt != 3'd0)           busy_cnt <= busy_cnt - 3'd1;
    end

    assign wb_stall = (PIPELINED == 0) && wb_cyc && (busy_cnt != 3'd0);

    wb_ack_pipe #(
        .DEPTH (ACK_LAT)
    ) u_ack_pipe (
        .clk       (system_clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (accept),
        .in_data   (wb_we ? 32'h0 : rd_data),
        .out_valid (wb_ack),
        .out_data  (wb_dat_r)
    );

`ifdef WB_EXT_REGBANK_IRQ_EN
    assign pend_clr = (accept && wb_we && region == RGN_PEND) ? wb_dat_w : 32'h0;

    // New rising edges are OR-ed in after the clear so a coincident edge survives.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            stat_prev <= '0;
            irq_pend  <= '0;
            irq_mask  <= '0;
            irq_q     <= 1'b0;
        end else begin
            stat_prev <= stat_in[31:0];
            irq_pend  <= (irq_pend & ~pend_clr) | (stat_in[31:0] & ~stat_prev);
            if (accept && wb_we && region == RGN_MASK)
                for (int unsigned k = 0; k < WB_SEL_W; k++)
                    if (wb_sel[k]) irq_mask[8*k +: 8] <= wb_dat_w[8*k +: 8];
            irq_q <= |(irq_pend & irq_mask);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_wb_ext_regbank.sv
// Bench for wb_ext_regbank: three instances (latency 1/2 pipelined, latency 3 classic) on a shared bus.
module tb_wb_ext_regbank;

    typedef struct packed {
        int          inst;
        int          cyc;
        logic [31:0] d;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc;
    logic [2:0]    stb;
    logic          we;
    logic [29:0]   adr;
    logic [31:0]   dat_w;
    logic [3:0]    sel;
    logic [127:0]  stat_v;
    logic          ack   [3];
    logic          stall [3];
    logic [31:0]   dat_r [3];
    logic [255:0]  ctrl  [3];
`ifdef WB_EXT_REGBANK_IRQ_EN
    logic          irq_o [3];
    logic [31:0]   pend_m;
    logic [31:0]   mask_m;
`endif

    logic [31:0]   ctrl_m [3][8];
    ev_t           ack_q[$];
    ev_t           exp_q[$];
    int            cyc_cnt = 0;
    int            total   = 0;
    int            passed  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk)
        if (!rst)
            for (int n = 0; n < 3; n++)
                if (ack[n]) ack_q.push_back(ev_t'{n, cyc_cnt, dat_r[n]});

    wb_ext_regbank #(.NUM_CTRL(8), .NUM_STAT(4), .ACK_LAT(1), .PIPELINED(1),
                     .BASE_ADDR(30'h0), .CTRL_RESET(32'hA5A5A5A5)) u0 (
        .system_clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb[0]), .wb_we(we),
        .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel), .wb_dat_r(dat_r[0]),
        .wb_ack(ack[0]), .wb_stall(stall[0]), .ctrl_out(ctrl[0]), .stat_in(stat_v)
`ifdef WB_EXT_REGBANK_IRQ_EN
        , .irq(irq_o[0])
`endif
    );

    wb_ext_regbank #(.NUM_CTRL(8), .NUM_STAT(4), .ACK_LAT(2), .PIPELINED(1),
                     .BASE_ADDR(30'h0), .CTRL_RESET(32'h0)) u1 (
        .system_clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb[1]), .wb_we(we),
        .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel), .wb_dat_r(dat_r[1]),
        .wb_ack(ack[1]), .wb_stall(stall[1]), .ctrl_out(ctrl[1]), .stat_in(stat_v)
`ifdef WB_EXT_REGBANK_IRQ_EN
        , .irq(irq_o[1])
`endif
    );

    wb_ext_regbank #(.NUM_CTRL(8), .NUM_STAT(4), .ACK_LAT(3), .PIPELINED(0),
                     .BASE_ADDR(30'h40), .CTRL_RESET(32'h0F0F0000)) u2 (
        .system_clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb[2]), .wb_we(we),
        .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel), .wb_dat_r(dat_r[2]),
        .wb_ack(ack[2]), .wb_stall(stall[2]), .ctrl_out(ctrl[2]), .stat_in(stat_v)
`ifdef WB_EXT_REGBANK_IRQ_EN
        , .irq(irq_o[2])
`endif
    );

    function automatic int lat_of(input int n);
        return n + 1;
    endfunction

    function automatic logic [31:0] reset_of(input int n);
        return (n == 0) ? 32'hA5A5A5A5 : (n == 1) ? 32'h0 : 32'h0F0F0000;
    endfunction

    function automatic logic [29:0] base_of(input int n);
        return (n == 2) ? 30'h40 : 30'h0;
    endfunction

    function automatic logic [31:0] exp_read(input int n, input int idx, input bit miss);
        if (miss)     return 32'hDEADBEEF;
        if (idx < 8)  return ctrl_m[n][idx];
        if (idx < 12) return stat_v[(idx-8)*32 +: 32];
`ifdef WB_EXT_REGBANK_IRQ_EN
        if (idx == 12) return pend_m;
        if (idx == 13) return mask_m;
`endif
        return 32'hDEADBEEF;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++)
            for (int w = 0; w < 8; w++) ctrl_m[n][w] = reset_of(n);
`ifdef WB_EXT_REGBANK_IRQ_EN
        pend_m = '0;
        mask_m = '0;
`endif
    endtask

    // Drives one request on instance n until accepted; t is the accept cycle (-1 on timeout).
    task automatic issue(input int n, input bit w, input int idx, input bit miss,
                         input logic [31:0] d, input logic [3:0] s, output int t);
        bit ok;
        ok    = 1'b0;
        t     = -1;
        cyc   = 1'b1;
        stb   = '0;
        stb[n] = 1'b1;
        we    = w;
        adr   = miss ? {24'(n + 5), 6'(idx)} : (base_of(n) | 30'(idx));
        dat_w = d;
        sel   = s;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (!stall[n]) begin
                ok = 1'b1;
                t  = cyc_cnt;
                exp_q.push_back(ev_t'{n, cyc_cnt + lat_of(n), w ? 32'h0 : exp_read(n, idx, miss)});
                if (w && !miss && idx < 8)
                    for (int b = 0; b < 4; b++)
                        if (s[b]) ctrl_m[n][idx][8*b +: 8] = d[8*b +: 8];
`ifdef WB_EXT_REGBANK_IRQ_EN
                if (w && !miss && idx == 12) pend_m = pend_m & ~d;
                if (w && !miss && idx == 13)
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mask_m[8*b +: 8] = d[8*b +: 8];
`endif
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            $display("FAIL issue_timeout inst=%0d idx=%0d got=stalled exp=accepted", n, idx);
        end
    endtask

    task automatic idle();
        stb = '0;
        we  = 1'b0;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            total++;
            if (ack[n] !== 1'b0 || stall[n] !== 1'b0 || dat_r[n] !== 32'h0)
                $display("FAIL reset_outputs inst=%0d got ack=%b stall=%b dat=%h exp 0/0/0",
                         n, ack[n], stall[n], dat_r[n]);
            else passed++;
            total++;
            if (ctrl[n] !== {8{reset_of(n)}})
                $display("FAIL reset_ctrl inst=%0d got=%h exp=%h", n, ctrl[n], {8{reset_of(n)}});
            else passed++;
`ifdef WB_EXT_REGBANK_IRQ_EN
            total++;
            if (irq_o[n] !== 1'b0) $display("FAIL reset_irq inst=%0d got=%b exp=0", n, irq_o[n]);
            else passed++;
`endif
        end
    endtask

    task automatic test_byte_write();
        int  t;
        ev_t g, e;
        for (int n = 0; n < 3; n += 2) begin
            issue(n, 1'b1, 2, 1'b0, 32'h12345678, 4'b0101, t);
            idle();
            total++;
            if (ctrl[n][95:64] !== ctrl_m[n][2])
                $display("FAIL byte_write_visible inst=%0d got=%h exp=%h", n, ctrl[n][95:64], ctrl_m[n][2]);
            else passed++;
            if (n == 0) begin
                total++;
                if (ctrl[0][95:64] !== 32'hA534A578)
                    $display("FAIL byte_write_value got=%h exp=a534a578", ctrl[0][95:64]);
                else passed++;
            end
            issue(n, 1'b0, 2, 1'b0, 32'h0, 4'hF, t);
            idle();
            repeat (6) @(posedge clk);
            #1;
            total++;
            if (ack_q.size() != exp_q.size())
                $display("FAIL byte_write_ack_count got=%0d exp=%0d", ack_q.size(), exp_q.size());
            else passed++;
            while (ack_q.size() > 0 && exp_q.size() > 0) begin
                g = ack_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (g !== e)
                    $display("FAIL byte_write_ack got=i%0d c%0d %h exp=i%0d c%0d %h",
                             g.inst, g.cyc, g.d, e.inst, e.cyc, e.d);
                else passed++;
            end
            ack_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int  t [4];
        ev_t g, e;
        for (int k = 0; k < 4; k++) issue(1, 1'b0, k, 1'b0, 32'h0, 4'hF, t[k]);
        idle();
        for (int k = 1; k < 4; k++) begin
            total++;
            if (t[k] !== t[0] + k)
                $display("FAIL b2b_accept k=%0d got=%0d exp=%0d", k, t[k], t[0] + k);
            else passed++;
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (ack_q.size() != exp_q.size())
            $display("FAIL b2b_ack_count got=%0d exp=%0d", ack_q.size(), exp_q.size());
        else passed++;
        while (ack_q.size() > 0 && exp_q.size() > 0) begin
            g = ack_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e)
                $display("FAIL b2b_ack got=i%0d c%0d %h exp=i%0d c%0d %h",
                         g.inst, g.cyc, g.d, e.inst, e.cyc, e.d);
            else passed++;
        end
        ack_q.delete();
        exp_q.delete();
    endtask

    task automatic test_classic_stall();
        int  t1, t2;
        ev_t g, e;
        issue(2, 1'b0, 5, 1'b0, 32'h0, 4'hF, t1);
        idle();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (stall[2] !== (k <= 3))
                $display("FAIL classic_stall cyc=T+%0d got=%b exp=%b", k, stall[2], (k <= 3));
            else passed++;
        end
        @(posedge clk);
        #1;
        issue(2, 1'b1, 6, 1'b0, 32'hCAFEF00D, 4'hF, t1);
        issue(2, 1'b0, 6, 1'b0, 32'h0, 4'hF, t2);
        idle();
        total++;
        if (t2 - t1 !== 4) $display("FAIL classic_next_accept got=T+%0d exp=T+4", t2 - t1);
        else passed++;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (ack_q.size() != exp_q.size())
            $display("FAIL classic_ack_count got=%0d exp=%0d", ack_q.size(), exp_q.size());
        else passed++;
        while (ack_q.size() > 0 && exp_q.size() > 0) begin
            g = ack_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e)
                $display("FAIL classic_ack got=i%0d c%0d %h exp=i%0d c%0d %h",
                         g.inst, g.cyc, g.d, e.inst, e.cyc, e.d);
            else passed++;
        end
        ack_q.delete();
        exp_q.delete();
    endtask

    task automatic test_unmapped_abort();
        int  t;
        ev_t g, e;
        ev_t dropped;
        issue(2, 1'b0, 63, 1'b0, 32'h0, 4'hF, t);
        idle();
        repeat (3) @(posedge clk);
        #1;
        issue(2, 1'b0, 1, 1'b0, 32'h0, 4'hF, t);
        cyc = 1'b0;
        idle();
        dropped = exp_q.pop_back();
        @(posedge clk);
        #1;
        cyc = 1'b1;
        @(negedge clk);
        total++;
        if (stall[2] !== 1'b0) $display("FAIL abort_stall got=%b exp=0", stall[2]);
        else passed++;
        repeat (5) @(posedge clk);
        #1;
        issue(2, 1'b0, 1, 1'b0, 32'h0, 4'hF, t);
        idle();
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (ack_q.size() != exp_q.size())
            $display("FAIL abort_ack_count got=%0d exp=%0d (dropped c%0d)", ack_q.size(), exp_q.size(), dropped.cyc);
        else passed++;
        while (ack_q.size() > 0 && exp_q.size() > 0) begin
            g = ack_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e)
                $display("FAIL abort_ack got=i%0d c%0d %h exp=i%0d c%0d %h",
                         g.inst, g.cyc, g.d, e.inst, e.cyc, e.d);
            else passed++;
        end
        ack_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int  t, idx;
        bit  w, miss;
        ev_t g, e;
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 30; k++) begin
                stat_v = {$urandom, $urandom, $urandom, $urandom};
                idx    = $urandom_range(63, 0);
`ifdef WB_EXT_REGBANK_IRQ_EN
                if (idx == 12 || idx == 13) idx = 63;
`endif
                if ($urandom_range(3, 0) == 0) idx = $urandom_range(11, 0);
                w    = $urandom_range(1, 0);
                miss = ($urandom_range(7, 0) == 0);
                issue(n, w, idx, miss, $urandom, 4'($urandom), t);
                if ($urandom_range(2, 0) == 0) begin
                    idle();
                    @(posedge clk);
                    #1;
                end
            end
            idle();
            repeat (6) @(posedge clk);
            #1;
            total++;
            if (ack_q.size() != exp_q.size())
                $display("FAIL random_ack_count inst=%0d got=%0d exp=%0d", n, ack_q.size(), exp_q.size());
            else passed++;
            while (ack_q.size() > 0 && exp_q.size() > 0) begin
                g = ack_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (g !== e)
                    $display("FAIL random_ack got=i%0d c%0d %h exp=i%0d c%0d %h",
                             g.inst, g.cyc, g.d, e.inst, e.cyc, e.d);
                else passed++;
            end
            ack_q.delete();
            exp_q.delete();
            for (int w2 = 0; w2 < 8; w2++) begin
                total++;
                if (ctrl[n][w2*32 +: 32] !== ctrl_m[n][w2])
                    $display("FAIL random_ctrl inst=%0d word=%0d got=%h exp=%h",
                             n, w2, ctrl[n][w2*32 +: 32], ctrl_m[n][w2]);
                else passed++;
            end
        end
    endtask

`ifdef WB_EXT_REGBANK_IRQ_EN
    task automatic test_irq();
        int  t;
        ev_t g, e;
        stat_v = '0;
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1'b1, 13, 1'b0, 32'h1, 4'hF, t);
        issue(0, 1'b1, 12, 1'b0, 32'hFFFFFFFF, 4'hF, t);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (irq_o[0] !== |(pend_m & mask_m)) $display("FAIL irq_cleared got=%b exp=0", irq_o[0]);
        else passed++;
        @(posedge clk);
        #1;
        stat_v[0] = 1'b1;
        pend_m[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (irq_o[0] !== |(pend_m & mask_m)) $display("FAIL irq_rise got=%b exp=1", irq_o[0]);
        else passed++;
        @(posedge clk);
        #1;
        stat_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        stat_v[0] = 1'b1;
        issue(0, 1'b1, 12, 1'b0, 32'h1, 4'hF, t);
        pend_m[0] = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (irq_o[0] !== |(pend_m & mask_m)) $display("FAIL irq_set_wins got=%b exp=1", irq_o[0]);
        else passed++;
        @(posedge clk);
        #1;
        issue(0, 1'b0, 12, 1'b0, 32'h0, 4'hF, t);
        issue(0, 1'b1, 12, 1'b0, 32'h1, 4'hF, t);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (irq_o[0] !== |(pend_m & mask_m)) $display("FAIL irq_w1c got=%b exp=0", irq_o[0]);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (ack_q.size() != exp_q.size())
            $display("FAIL irq_ack_count got=%0d exp=%0d", ack_q.size(), exp_q.size());
        else passed++;
        while (ack_q.size() > 0 && exp_q.size() > 0) begin
            g = ack_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e)
                $display("FAIL irq_ack got=i%0d c%0d %h exp=i%0d c%0d %h",
                         g.inst, g.cyc, g.d, e.inst, e.cyc, e.d);
            else passed++;
        end
        ack_q.delete();
        exp_q.delete();
    endtask
`endif

    task automatic test_async_reset();
        int  t;
        ev_t dropped;
        issue(2, 1'b0, 0, 1'b0, 32'h0, 4'hF, t);
        idle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        dropped = exp_q.pop_back();
        total++;
        if (ack[2] !== 1'b0 || stall[2] !== 1'b0 || dat_r[2] !== 32'h0)
            $display("FAIL async_reset_outputs got ack=%b stall=%b dat=%h exp 0/0/0 (c%0d)",
                     ack[2], stall[2], dat_r[2], dropped.cyc);
        else passed++;
        for (int n = 0; n < 3; n++) begin
            total++;
            if (ctrl[n] !== {8{reset_of(n)}})
                $display("FAIL async_reset_ctrl inst=%0d got=%h exp=%h", n, ctrl[n], {8{reset_of(n)}});
            else passed++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (ack_q.size() != 0) $display("FAIL async_reset_no_ack got=%0d exp=0", ack_q.size());
        else passed++;
        ack_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst    = 1'b1;
        cyc    = 1'b0;
        stb    = '0;
        we     = 1'b0;
        adr    = '0;
        dat_w  = '0;
        sel    = '0;
        stat_v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        @(posedge clk);
        #1;
        test_byte_write();
        test_back_to_back();
        test_classic_stall();
        test_unmapped_abort();
        test_random();
`ifdef WB_EXT_REGBANK_IRQ_EN
        test_irq();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
